// File: rtl/hold_piece_if.sv
// Signal bundle between the hold controller (slave) and the game engine /
// piece generator side (master).
interface hold_piece_if;
  logic       hold_key;
  logic       frame_tick;
  logic [2:0] cur_shape;
  logic       piece_locked;
  logic       spawn_ack;
  logic [2:0] next_shape;
  logic       spawn_req;
  logic       load_new;
  logic [2:0] new_shape;
  logic [2:0] hold_shape;
  logic [9:0] hold_size_x;
  logic [9:0] hold_size_y;
  logic       hold_busy;

  modport master (
    output hold_key, frame_tick, cur_shape, piece_locked, spawn_ack, next_shape,
    input  spawn_req, load_new, new_shape, hold_shape, hold_size_x, hold_size_y,
           hold_busy
  );

  modport slave (
    input  hold_key, frame_tick, cur_shape, piece_locked, spawn_ack, next_shape,
    output spawn_req, load_new, new_shape, hold_shape, hold_size_x, hold_size_y,
           hold_busy
  );
endinterface

// File: rtl/hold_piece_ctrl.sv
// Tetris hold-piece sequencer: swaps or stashes the falling piece on a frame
// tick, fetching a fresh piece from the generator when the hold slot is empty.
//
// state      | meaning
// IDLE       | waiting for an accepted hold press
// WAIT_FRAME | press latched, swap deferred to the next frame tick
// FETCH      | hold slot was empty, waiting for the generator to spawn a piece
// LOAD       | one-cycle load_new pulse to the game engine
module hold_piece_ctrl #(
  parameter int FETCH_TIMEOUT = 1024,
  parameter int CNT_W         = 10
) (
  input logic         Clk,
  input logic         Reset_n,
  hold_piece_if.slave hp
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    FETCH      = 2'd2,
    LOAD       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t           state, state_nx;
  logic [1:0]       key_sync;
  logic             key_prev;
  logic             press;
  logic [2:0]       saved_shape, saved_nx;
  logic [2:0]       hold_r, hold_nx;
  logic [2:0]       new_r, new_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             allowed, allowed_nx;
  logic             aborted, aborted_nx;
  logic [9:0]       size_x, size_y;

  assign press = key_sync[1] & ~key_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      key_sync    <= 2'b00;
      key_prev    <= 1'b0;
      saved_shape <= 3'd0;
      hold_r      <= 3'd0;
      new_r       <= 3'd0;
      cnt         <= '0;
      allowed     <= 1'b1;
      aborted     <= 1'b0;
      size_x      <= 10'd0;
      size_y      <= 10'd0;
    end else begin
      key_sync    <= {key_sync[0], hp.hold_key};
      key_prev    <= key_sync[1];
      state       <= state_nx;
      saved_shape <= saved_nx;
      hold_r      <= hold_nx;
      new_r       <= new_nx;
      cnt         <= cnt_nx;
      allowed     <= allowed_nx;
      aborted     <= aborted_nx;
      // Sizes track the registered hold shape, so they lag it by one cycle.
      case (hold_r)
        3'd0:    begin size_x <= 10'd0;  size_y <= 10'd0;  end
        3'd1:    begin size_x <= 10'd64; size_y <= 10'd16; end
        3'd2:    begin size_x <= 10'd32; size_y <= 10'd32; end
        default: begin size_x <= 10'd48; size_y <= 10'd32; end
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    saved_nx   = saved_shape;
    hold_nx    = hold_r;
    new_nx     = new_r;
    cnt_nx     = cnt;
    allowed_nx = allowed;
    aborted_nx = aborted;
    case (state)
      IDLE: begin
        if (hp.piece_locked) allowed_nx = 1'b1;
        if (press && allowed && (hp.cur_shape != 3'd0)) begin
          saved_nx = hp.cur_shape;
          state_nx = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        // A landing piece cancels the pending hold, even on the tick itself.
        if (hp.piece_locked) begin
          state_nx = IDLE;
        end else if (hp.frame_tick) begin
          hold_nx = saved_shape;
          if (hold_r != 3'd0) begin
            new_nx     = hold_r;
            aborted_nx = 1'b0;
            state_nx   = LOAD;
          end else begin
            cnt_nx   = '0;
            state_nx = FETCH;
          end
        end
      end
      FETCH: begin
        if (hp.spawn_ack) begin
          new_nx     = hp.next_shape;
          aborted_nx = 1'b0;
          state_nx   = LOAD;
        end else if (cnt == CNT_LAST) begin
          // Generator never answered: give the original piece back.
          hold_nx    = 3'd0;
          new_nx     = saved_shape;
          aborted_nx = 1'b1;
          state_nx   = LOAD;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      LOAD: begin
        if (!aborted) allowed_nx = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hp.spawn_req   = (state == FETCH);
  assign hp.load_new    = (state == LOAD);
  assign hp.hold_busy   = (state != IDLE);
  assign hp.new_shape   = new_r;
  assign hp.hold_shape  = hold_r;
  assign hp.hold_size_x = size_x;
  assign hp.hold_size_y = size_y;

endmodule

// File: doc/hold_piece_ctrl.md
Name: hold_piece_ctrl

Overview:
Sequences the Tetris "hold" feature. On a hold keypress it swaps the falling piece with the held piece, or stashes the falling piece and fetches a fresh one from the piece generator when hold is empty. Swaps are committed only on a frame tick. It maintains the held shape and its registered pixel size for the hold-box renderer, and enforces one hold per dropped piece.

Parameters:
FETCH_TIMEOUT, 1024, cycles to wait for spawn_ack before aborting a fetch
CNT_W, 10, width of timeout counter; must hold FETCH_TIMEOUT

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
hold_key  input  1  raw hold key level from keyboard decoder (asynchronous to game logic)
frame_tick  input  1  one-cycle pulse at vertical blank
cur_shape  input  3  shape of falling piece; 0 = none, 1 = I, 2 = O, 3..7 = others
piece_locked  input  1  one-cycle pulse when falling piece lands
spawn_ack  input  1  generator handshake; next_shape valid this cycle
next_shape  input  3  shape supplied by generator
spawn_req  output  1  request a new piece from generator
load_new  output  1  one-cycle pulse; game engine replaces falling piece with new_shape
new_shape  output  3  shape to load; valid when load_new = 1
hold_shape  output  3  currently held shape; 0 = empty
hold_size_x  output  10  pixel width of held shape
hold_size_y  output  10  pixel height of held shape
hold_busy  output  1  high when state != IDLE; engine freezes gravity while high

Behaviour:
- Reset (async, Reset_n = 0): state IDLE; hold_shape, new_shape, saved_shape, timeout counter, sync flops = 0; spawn_req, load_new, hold_busy = 0; hold_size_x/y = 0; hold_allowed = 1.
- hold_key passes through a 2-flop synchronizer. A rising edge on the synchronized signal is a hold request (press), valid from 3 cycles after the pin rises.
- States: IDLE, WAIT_FRAME, FETCH, LOAD.
- IDLE:
  - A press with hold_allowed = 1 and cur_shape != 0 latches saved_shape = cur_shape and moves to WAIT_FRAME.
  - A press is ignored otherwise.
  - piece_locked sets hold_allowed = 1.
- WAIT_FRAME:
  - On frame_tick with hold_shape != 0: new_shape = hold_shape, hold_shape = saved_shape, go to LOAD.
  - On frame_tick with hold_shape = 0: hold_shape = saved_shape, go to FETCH with spawn_req = 1.
  - piece_locked in WAIT_FRAME (same cycle as frame_tick or earlier): abort to IDLE with no swap; hold_allowed stays 1. Lock has priority over frame_tick.
- FETCH:
  - spawn_req held high until spawn_ack.
  - On spawn_ack: new_shape = next_shape, spawn_req = 0, go to LOAD. next_shape = 0 is treated as valid and passed through.
  - Counter counts from 0. If it reaches FETCH_TIMEOUT-1 without spawn_ack: abort. hold_shape reverts to 0, new_shape = saved_shape, spawn_req = 0, go to LOAD (engine reloads the original piece). hold_allowed is left at 1.
  - spawn_ack and timeout in the same cycle: ack wins.
- LOAD:
  - load_new = 1 for exactly this cycle, then return to IDLE.
  - hold_allowed cleared, except after a timeout abort.
- piece_locked in FETCH/LOAD is ignored; gravity is frozen via hold_busy.
- Key presses outside IDLE are ignored (not queued).
- Size lookup is registered: one cycle after hold_shape changes.
  - hold_shape 1: 64x16
  - hold_shape 2: 32x32
  - hold_shape 3..7: 48x32
  - hold_shape 0: 0x0
- Latency, press-sync-edge to load_new:
  - Swap path: frame_tick cycle + 1.
  - Fetch path: spawn_ack cycle + 1.

Test Plan:
- Reset, cur_shape=3, hold empty, press, frame_tick, spawn_ack with next_shape=1 -> hold_shape=3, size 48x32, spawn_req high until ack, load_new pulse with new_shape=1 one cycle after ack, hold_busy low after.
- Hold=3, cur_shape=2, hold_allowed=1, press, frame_tick -> load_new with new_shape=3, hold_shape=2, size 32x32 next cycle; no spawn_req.
- After a swap, press again before piece_locked -> no state change. Pulse piece_locked then press -> swap accepted.
- Press, then piece_locked and frame_tick in same cycle -> back to IDLE, no load_new, hold_shape unchanged.
- Hold empty, cur_shape=1, press, frame_tick, no spawn_ack for FETCH_TIMEOUT cycles (set 16) -> hold_shape returns to 0, load_new with new_shape=1, hold_allowed still 1.
- Assert Reset_n low mid-FETCH -> outputs immediately 0, spawn_req drops asynchronously, state IDLE, hold_allowed=1.
